heap_dma: RTL and testbench

//  Command-driven access engine on the initiator side of the Heap port (WR/ADDR/iData/oData).

---
 rtl/heap_pkg.sv | 28 ++
 rtl/heap_dma_ctr.sv | 46 ++++
 rtl/heap_dma.sv | 163 ++++++++++++++++
 tb/tb_heap_dma.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/heap_pkg.sv
// ---------------------------------------------------------------------------
// heap_pkg
// Shared constants and enums for the Heap access engine (heap_dma).
//   HEAP_AW / HEAP_DW : default Heap address / data widths (32 x 8 Heap)
//   op_e              : command opcodes as they appear on cmd_op_i
//   state_e           : engine FSM states
// ---------------------------------------------------------------------------
package heap_pkg;

  localparam int HEAP_AW = 5;
  localparam int HEAP_DW = 8;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_FILL = 2'b01,
    OP_COPY = 2'b10,
    OP_SUM  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_CP_RD,
    ST_CP_WR,
    ST_SUM
  } state_e;

endpackage

// File: rtl/heap_dma_ctr.sv
// ---------------------------------------------------------------------------
// heap_dma_ctr
// Offset / remaining-length counter for one heap_dma operation.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : start of operation, offset <= 0, remaining <= len_i
//   step_i        : one byte finished, offset++, remaining--
//   len_i         : byte count 0..2**AW
//   offset_o      : current byte offset i (wraps mod 2**AW)
//   last_o        : the byte currently being processed is the final one
// ---------------------------------------------------------------------------
module heap_dma_ctr
  import heap_pkg::*;
#(
  parameter int AW = HEAP_AW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [AW:0]   len_i,
  output logic [AW-1:0] offset_o,
  output logic          last_o
);

  logic [AW-1:0] offset_q;
  logic [AW:0]   remain_q;

  // Remaining count is one bit wider than the offset so a full-Heap
  // length (2**AW) is representable; it never steps below zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      offset_q <= '0;
      remain_q <= '0;
    end else if (load_i) begin
      offset_q <= '0;
      remain_q <= len_i;
    end else if (step_i && (remain_q != '0)) begin
      offset_q <= offset_q + AW'(1);
      remain_q <= remain_q - (AW+1)'(1);
    end
  end

  assign offset_o = offset_q;
  assign last_o   = (remain_q == (AW+1)'(1));

endmodule

// File: rtl/heap_dma.sv
// ---------------------------------------------------------------------------
// heap_dma
// Command-driven FILL / COPY / SUM engine driving the Heap port, one access
// per cycle. Owns the Heap port while busy.
// Optional feature macro: HEAP_DMA_SUM_EN (SUM op; when undefined, op 11 is
// treated as NOP and result_o stays 0).
// Ports:
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   cmd_valid_i/ready_o   : command handshake (ready only while idle)
//   cmd_op_i              : 00 NOP, 01 FILL, 10 COPY, 11 SUM
//   cmd_src_i, cmd_dst_i  : source / destination start addresses
//   cmd_len_i             : byte count 0..2**AW
//   cmd_data_i            : fill value
//   busy_o, done_o        : operation in progress / one-cycle completion pulse
//   result_o              : SUM result, valid with done_o
//   h_wr_o, h_addr_o, h_wdata_o, h_rdata_i : Heap port (rdata combinational)
// ---------------------------------------------------------------------------
module heap_dma
  import heap_pkg::*;
#(
  parameter int AW = HEAP_AW,
  parameter int DW = HEAP_DW
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [1:0]    cmd_op_i,
  input  logic [AW-1:0] cmd_src_i,
  input  logic [AW-1:0] cmd_dst_i,
  input  logic [AW:0]   cmd_len_i,
  input  logic [DW-1:0] cmd_data_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [DW-1:0] result_o,
  output logic          h_wr_o,
  output logic [AW-1:0] h_addr_o,
  output logic [DW-1:0] h_wdata_o,
  input  logic [DW-1:0] h_rdata_i
);

  state_e        state_q;
  logic [AW-1:0] src_q, dst_q;
  logic [AW-1:0] h_addr_q;
  logic [DW-1:0] h_wdata_q, result_q;
  logic          h_wr_q, done_q;

  logic [AW-1:0] offset, offset_d;
  logic          last, accept, step;

  assign accept   = cmd_valid_i && (state_q == ST_IDLE);
  assign step     = (state_q == ST_FILL) || (state_q == ST_CP_WR) || (state_q == ST_SUM);
  assign offset_d = offset + AW'(1);

  heap_dma_ctr #(.AW(AW)) u_ctr (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (accept),
    .step_i   (step),
    .len_i    (cmd_len_i),
    .offset_o (offset),
    .last_o   (last)
  );

  // Main FSM. All Heap-port outputs are registered, so every state
  // pre-computes the address/strobe for the following cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      h_wr_q    <= 1'b0;
      h_addr_q  <= '0;
      h_wdata_q <= '0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            src_q    <= cmd_src_i;
            dst_q    <= cmd_dst_i;
            result_q <= '0;
            if (cmd_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              case (op_e'(cmd_op_i))
                OP_FILL: begin
                  state_q   <= ST_FILL;
                  h_wr_q    <= 1'b1;
                  h_addr_q  <= cmd_dst_i;
                  h_wdata_q <= cmd_data_i;
                end
                OP_COPY: begin
                  state_q  <= ST_CP_RD;
                  h_addr_q <= cmd_src_i;
                end
`ifdef HEAP_DMA_SUM_EN
                OP_SUM: begin
                  state_q  <= ST_SUM;
                  h_addr_q <= cmd_src_i;
                end
`endif
                default: done_q <= 1'b1;
              endcase
            end
          end
        end
        ST_FILL: begin
          if (last) begin
            state_q <= ST_IDLE;
            h_wr_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            h_addr_q <= dst_q + offset_d;
          end
        end
        ST_CP_RD: begin
          // The counter only steps after the write, so offset still names this byte.
          state_q   <= ST_CP_WR;
          h_wr_q    <= 1'b1;
          h_wdata_q <= h_rdata_i;
          h_addr_q  <= dst_q + offset;
        end
        ST_CP_WR: begin
          h_wr_q <= 1'b0;
          if (last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            state_q  <= ST_CP_RD;
            h_addr_q <= src_q + offset_d;
          end
        end
`ifdef HEAP_DMA_SUM_EN
        ST_SUM: begin
          result_q <= result_q + h_rdata_i;
          if (last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            h_addr_q <= src_q + offset_d;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          h_wr_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign result_o    = result_q;
  assign h_wr_o      = h_wr_q;
  assign h_addr_o    = h_addr_q;
  assign h_wdata_o   = h_wdata_q;

endmodule

// File: tb/tb_heap_dma.sv
// ---------------------------------------------------------------------------
// tb_heap_dma
// Scoreboard bench for heap_dma. Each directed command pushes its expected
// Heap writes and DONE event (with the cycle they should appear in, counted
// from the accepting edge) into a queue; a monitor pops and compares every
// time the engine writes or pulses done. The 32x8 Heap lives in the bench.
// Expectations for SUM follow the HEAP_DMA_SUM_EN macro.
// ---------------------------------------------------------------------------
module tb_heap_dma;
  import heap_pkg::*;

  typedef struct {
    bit         isDone;
    int         rel;
    logic [4:0] addr;
    logic [7:0] data;
  } exp_t;

  logic       clock = 1'b0;
  logic       rstN  = 1'b0;
  logic       cmdValid = 1'b0;
  logic       cmdReady;
  logic [1:0] cmdOp = 2'b00;
  logic [4:0] cmdSrc = '0, cmdDst = '0;
  logic [5:0] cmdLen = '0;
  logic [7:0] cmdData = '0;
  logic       busy, done;
  logic [7:0] result;
  logic       hWr;
  logic [4:0] hAddr;
  logic [7:0] hWdata, hRdata;

  logic [7:0] mem [0:31];
  exp_t       expQ [$];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         anchorCyc = 0;

  heap_dma dut (
    .clk_i       (clock),
    .rst_ni      (rstN),
    .cmd_valid_i (cmdValid),
    .cmd_ready_o (cmdReady),
    .cmd_op_i    (cmdOp),
    .cmd_src_i   (cmdSrc),
    .cmd_dst_i   (cmdDst),
    .cmd_len_i   (cmdLen),
    .cmd_data_i  (cmdData),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result),
    .h_wr_o      (hWr),
    .h_addr_o    (hAddr),
    .h_wdata_o   (hWdata),
    .h_rdata_i   (hRdata)
  );

  // Free-running 100 MHz clock.
  always #5 clock = ~clock;

  // Cycle counter used to time-stamp observed events against the accept edge.
  always @(posedge clock) cyc <= cyc + 1;

  // The Heap itself: combinational read, write on the rising edge.
  assign hRdata = mem[hAddr];
  always @(posedge clock) if (hWr) mem[hAddr] <= hWdata;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  function automatic void pushWrite(input int rel, input logic [4:0] a, input logic [7:0] d);
    exp_t e;
    e.isDone = 1'b0; e.rel = rel; e.addr = a; e.data = d;
    expQ.push_back(e);
  endfunction

  function automatic void pushDone(input int rel, input logic [7:0] r);
    exp_t e;
    e.isDone = 1'b1; e.rel = rel; e.addr = '0; e.data = r;
    expQ.push_back(e);
  endfunction

  // Monitor: on every write or done pulse, pop the oldest expectation and
  // compare kind, cycle, and address/data (or result).
  always @(negedge clock) begin : monitor
    exp_t e;
    int   rel;
    if (rstN && (hWr || done)) begin
      rel = cyc - anchorCyc;
      if (expQ.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected-event: got wr=%0b done=%0b addr=%0d data=%0h at cycle %0d, required none",
                 hWr, done, hAddr, hWdata, rel);
      end else begin
        e = expQ.pop_front();
        checkOutput("event-kind(done)", 32'(done), 32'(e.isDone));
        checkOutput("event-cycle", 32'(rel), 32'(e.rel));
        if (e.isDone) begin
          checkOutput("done-result", 32'(result), 32'(e.data));
        end else begin
          checkOutput("write-addr", 32'(hAddr), 32'(e.addr));
          checkOutput("write-data", 32'(hWdata), 32'(e.data));
        end
      end
    end
  end

  task automatic restoreHeap();
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
  endtask

  // Offer one command, wait (bounded) until it is taken, then drop valid.
  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] src, input logic [4:0] dst,
                               input logic [5:0] len, input logic [7:0] data);
    int n = 0;
    @(negedge clock);
    cmdOp = op; cmdSrc = src; cmdDst = dst; cmdLen = len; cmdData = data;
    cmdValid = 1'b1;
    while (!cmdReady && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (!cmdReady) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept-timeout: got ready=0, required ready=1");
    end
    @(posedge clock);
    #1;
    anchorCyc = cyc - 1;
    cmdValid = 1'b0;
  endtask

  // Wait (bounded) until every expected event has been observed.
  task automatic drainQueue(input string name);
    int n = 0;
    while (expQ.size() != 0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (expQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s-timeout: got %0d events outstanding, required 0", name, expQ.size());
      expQ.delete();
    end
    @(negedge clock);
  endtask

  // Hard stop in case anything hangs outside the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, required finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    restoreHeap();
    repeat (2) @(negedge clock);
    checkOutput("reset-ready", 32'(cmdReady), 32'd1);
    checkOutput("reset-busy", 32'(busy), 32'd0);
    checkOutput("reset-done", 32'(done), 32'd0);
    checkOutput("reset-result", 32'(result), 32'd0);
    checkOutput("reset-hwr", 32'(hWr), 32'd0);
    checkOutput("reset-haddr", 32'(hAddr), 32'd0);
    checkOutput("reset-hwdata", 32'(hWdata), 32'd0);
    rstN = 1'b1;

    // FILL dst=4 len=3 data=A5
    pushWrite(1, 5'd4, 8'hA5); pushWrite(2, 5'd5, 8'hA5); pushWrite(3, 5'd6, 8'hA5);
    pushDone(4, 8'h00);
    applyStimulus(OP_FILL, 5'd0, 5'd4, 6'd3, 8'hA5);
    drainQueue("fill");
    checkOutput("fill-heap3", 32'(mem[3]), 32'h03);
    checkOutput("fill-heap5", 32'(mem[5]), 32'hA5);
    checkOutput("fill-heap7", 32'(mem[7]), 32'h07);

    // COPY src=0 dst=16 len=4
    pushWrite(2, 5'd16, 8'h00); pushWrite(4, 5'd17, 8'h01);
    pushWrite(6, 5'd18, 8'h02); pushWrite(8, 5'd19, 8'h03);
    pushDone(9, 8'h00);
    applyStimulus(OP_COPY, 5'd0, 5'd16, 6'd4, 8'h00);
    drainQueue("copy");
    checkOutput("copy-heap19", 32'(mem[19]), 32'h03);
    checkOutput("copy-heap20", 32'(mem[20]), 32'h14);

    // FILL with address wrap dst=30 len=4
    pushWrite(1, 5'd30, 8'h11); pushWrite(2, 5'd31, 8'h11);
    pushWrite(3, 5'd0, 8'h11);  pushWrite(4, 5'd1, 8'h11);
    pushDone(5, 8'h00);
    applyStimulus(OP_FILL, 5'd0, 5'd30, 6'd4, 8'h11);
    drainQueue("wrap");
    checkOutput("wrap-heap29", 32'(mem[29]), 32'h1D);
    checkOutput("wrap-heap2", 32'(mem[2]), 32'h02);

    // LEN=0 and NOP complete at cycle 1 with no access
    pushDone(1, 8'h00);
    applyStimulus(OP_FILL, 5'd0, 5'd8, 6'd0, 8'hFF);
    drainQueue("len0");
    checkOutput("len0-heap8", 32'(mem[8]), 32'h08);
    pushDone(1, 8'h00);
    applyStimulus(OP_NOP, 5'd0, 5'd8, 6'd5, 8'hFF);
    drainQueue("nop");

    // SUM over the whole Heap, then a wrapping two-byte SUM
    restoreHeap();
`ifdef HEAP_DMA_SUM_EN
    pushDone(33, 8'hF0);
`else
    pushDone(1, 8'h00);
`endif
    applyStimulus(OP_SUM, 5'd0, 5'd0, 6'd32, 8'h00);
    drainQueue("sum-full");
`ifdef HEAP_DMA_SUM_EN
    pushDone(3, 8'h1F);
`else
    pushDone(1, 8'h00);
`endif
    applyStimulus(OP_SUM, 5'd31, 5'd0, 6'd2, 8'h00);
    drainQueue("sum-wrap");

    // Back-to-back: second command held valid, taken on the DONE edge
    pushWrite(1, 5'd10, 8'h22); pushWrite(2, 5'd11, 8'h22); pushDone(3, 8'h00);
    pushWrite(4, 5'd12, 8'h33); pushDone(5, 8'h00);
    applyStimulus(OP_FILL, 5'd0, 5'd10, 6'd2, 8'h22);
    cmdOp = OP_FILL; cmdDst = 5'd12; cmdLen = 6'd1; cmdData = 8'h33;
    cmdValid = 1'b1;
    for (int n = 0; n < 20 && !cmdReady; n++) @(negedge clock);
    @(posedge clock);
    #1;
    cmdValid = 1'b0;
    drainQueue("b2b");
    checkOutput("b2b-heap12", 32'(mem[12]), 32'h33);

    // Command offered while busy must be dropped
    restoreHeap();
    pushWrite(1, 5'd8, 8'h44); pushWrite(2, 5'd9, 8'h44);
    pushWrite(3, 5'd10, 8'h44); pushWrite(4, 5'd11, 8'h44);
    pushDone(5, 8'h00);
    applyStimulus(OP_FILL, 5'd0, 5'd8, 6'd4, 8'h44);
    @(negedge clock);
    cmdOp = OP_FILL; cmdDst = 5'd0; cmdLen = 6'd1; cmdData = 8'hEE;
    cmdValid = 1'b1;
    repeat (2) @(negedge clock);
    cmdValid = 1'b0;
    drainQueue("busy-ignore");
    checkOutput("busy-ignore-heap0", 32'(mem[0]), 32'h00);

    // Overlapping forward copy replicates the first byte
    restoreHeap();
    pushWrite(2, 5'd3, 8'h02); pushWrite(4, 5'd4, 8'h02); pushWrite(6, 5'd5, 8'h02);
    pushDone(7, 8'h00);
    applyStimulus(OP_COPY, 5'd2, 5'd3, 6'd3, 8'h00);
    drainQueue("overlap");
    checkOutput("overlap-heap6", 32'(mem[6]), 32'h06);

    // Reset during COPY cycle 3: engine idles at once, no DONE follows
    restoreHeap();
    pushWrite(2, 5'd20, 8'h00);
    applyStimulus(OP_COPY, 5'd0, 5'd20, 6'd4, 8'h00);
    @(posedge clock);
    @(posedge clock);
    #1;
    rstN = 1'b0;
    #1;
    checkOutput("midreset-busy", 32'(busy), 32'd0);
    checkOutput("midreset-hwr", 32'(hWr), 32'd0);
    checkOutput("midreset-ready", 32'(cmdReady), 32'd1);
    repeat (2) @(negedge clock);
    rstN = 1'b1;
    checkOutput("midreset-outstanding", 32'(expQ.size()), 32'd0);
    checkOutput("midreset-heap20", 32'(mem[20]), 32'h00);
    checkOutput("midreset-heap21", 32'(mem[21]), 32'h15);
    pushWrite(1, 5'd21, 8'h77); pushDone(2, 8'h00);
    applyStimulus(OP_FILL, 5'd0, 5'd21, 6'd1, 8'h77);
    drainQueue("after-reset");
    checkOutput("after-reset-heap21", 32'(mem[21]), 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
